// File: rtl/cmul_rr_arbiter_pkg.sv
// rtl/cmul_rr_arbiter_pkg.sv - shared constants, complex operand type and index-width helper
//
// Contents:
//   CMUL_W     operand/result width (signed Q4.4)
//   CMUL_FRAC  number of fraction bits
//   cplx_t     packed complex value {re, im}
//   idx_w(n)   width of an index able to address n requesters (at least 1)
package cmul_pkg;

  localparam int CMUL_W    = 8;
  localparam int CMUL_FRAC = 4;

  typedef struct packed {
    logic signed [CMUL_W-1:0] re;
    logic signed [CMUL_W-1:0] im;
  } cplx_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmul_rr_arbiter_if.sv
// rtl/cmul_rr_arbiter_if.sv - requester and response bus of the shared complex multiplier
//
// Signals:
//   req_valid  [NREQ]      per-requester operand valid
//   req_ready  [NREQ]      per-requester grant (one-hot or zero)
//   req_a/aj   [NREQ*W]    operand A real/imag, requester i at [i*W +: W]
//   req_b/bj   [NREQ*W]    operand B real/imag
//   rsp_valid  [1]         product valid
//   rsp_ready  [1]         downstream accepts product
//   rsp_c/cj   [W]         product real/imag
//   rsp_id     [idx_w]     requester that produced the product
// Modports: master = requesters plus downstream sink, slave = arbiter.
interface cmul_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  import cmul_pkg::*;

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_aj;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*W-1:0] req_bj;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_c;
  logic [W-1:0]      rsp_cj;
  logic [IW-1:0]     rsp_id;

  modport master (
    output req_valid, req_a, req_aj, req_b, req_bj, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_cj, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_aj, req_b, req_bj, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_cj, rsp_id
  );

endinterface

// File: rtl/cmul_rr_arbiter_rr_pick.sv
// rtl/cmul_rr_arbiter_rr_pick.sv - combinational round-robin priority picker
//
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index of the last grant; search starts at ptr+1
//   en   in  1   picker enable; no grant when low
//   gnt  out N   one-hot grant (zero when none)
//   idx  out IW  encoded index of the grant
//   any  out 1   a grant was made
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Walk ptr+1 .. ptr+N (mod N); the first valid requester wins, so the
  // last winner is visited last and every valid requester waits at most N
  // grants.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (en && !any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/complex_mul.sv
// rtl/complex_mul.sv - combinational signed fixed-point complex multiplier
//
// Ports:
//   a, aj   in  W  operand A real/imag (signed, FRAC fraction bits)
//   b, bj   in  W  operand B real/imag
//   c, cj   out W  product real/imag
// Products are summed at full precision, scaled back by truncation toward
// zero and saturated to the W-bit signed range.
module complex_mul
  import cmul_pkg::*;
#(
  parameter int W    = CMUL_W,
  parameter int FRAC = CMUL_FRAC
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] aj,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] bj,
  output logic signed [W-1:0] c,
  output logic signed [W-1:0] cj
);

  // One extra bit over a single product holds the sum/difference of two.
  localparam int PW = 2 * W + 1;
  localparam logic signed [PW-1:0] MAXV = PW'((1 << (W - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  localparam logic signed [PW-1:0] BIAS = PW'((1 << FRAC) - 1);
  localparam logic signed [PW-1:0] ZERO = '0;

  logic signed [2*W-1:0] p_rr;
  logic signed [2*W-1:0] p_ii;
  logic signed [2*W-1:0] p_ri;
  logic signed [2*W-1:0] p_ir;
  logic signed [PW-1:0]  re_full;
  logic signed [PW-1:0]  im_full;

  assign p_rr = a * b;
  assign p_ii = aj * bj;
  assign p_ri = a * bj;
  assign p_ir = aj * b;

  assign re_full = PW'(p_rr) - PW'(p_ii);
  assign im_full = PW'(p_ri) + PW'(p_ir);

  // Biasing negatives by 2^FRAC-1 before the arithmetic shift turns the
  // floor of >>> into truncation toward zero.
  function automatic logic signed [W-1:0] scale(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] q;
    q = v + (v[PW-1] ? BIAS : ZERO);
    q = q >>> FRAC;
    if (q > MAXV) begin
      return MAXV[W-1:0];
    end
    if (q < MINV) begin
      return MINV[W-1:0];
    end
    return q[W-1:0];
  endfunction

  assign c  = scale(re_full);
  assign cj = scale(im_full);

endmodule

// File: rtl/cmul_rr_arbiter.sv
// rtl/cmul_rr_arbiter.sv - round-robin sharing of one complex multiplier with a registered response
//
// Ports:
//   clk       in   1     rising-edge clock
//   rst_n     in   1     synchronous active-low reset
//   bus       slave       requester operands/grants and response handshake
//   op_count  out  CNTW  saturating count of accepted operations
module cmul_rr_arbiter
  import cmul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = CMUL_W,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cmul_rr_arbiter_if.slave    bus,
  output logic [CNTW-1:0]     op_count
);

  localparam int IW = idx_w(NREQ);

  logic          rsp_valid_q;
  logic [W-1:0]  rsp_c_q;
  logic [W-1:0]  rsp_cj_q;
  logic [IW-1:0] rsp_id_q;
  logic [IW-1:0] ptr_q;
  logic [CNTW-1:0] cnt_q;

  logic          free;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0] sel;
  logic          accept;

  logic [W-1:0] a_arr  [NREQ];
  logic [W-1:0] aj_arr [NREQ];
  logic [W-1:0] b_arr  [NREQ];
  logic [W-1:0] bj_arr [NREQ];

  logic signed [W-1:0] mul_c;
  logic signed [W-1:0] mul_cj;

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign a_arr[i]  = bus.req_a[i*W +: W];
    assign aj_arr[i] = bus.req_aj[i*W +: W];
    assign b_arr[i]  = bus.req_b[i*W +: W];
    assign bj_arr[i] = bus.req_bj[i*W +: W];
  end

  // A draining response frees the buffer in the same cycle, which is what
  // gives one product per cycle under rsp_ready=1. Gating with rst_n keeps
  // every grant low during a reset cycle.
  assign free = !rsp_valid_q || bus.rsp_ready;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .en  (free && rst_n),
    .gnt (gnt),
    .idx (sel),
    .any (accept)
  );

  complex_mul #(
    .W    (W),
    .FRAC (CMUL_FRAC)
  ) u_mul (
    .a  ($signed(a_arr[sel])),
    .aj ($signed(aj_arr[sel])),
    .b  ($signed(b_arr[sel])),
    .bj ($signed(bj_arr[sel])),
    .c  (mul_c),
    .cj (mul_cj)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_cj_q    <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= IW'(NREQ - 1);
      cnt_q       <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_c_q     <= mul_c;
      rsp_cj_q    <= mul_cj;
      rsp_id_q    <= sel;
      ptr_q       <= sel;
      if (cnt_q != {CNTW{1'b1}}) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end else if (bus.rsp_ready) begin
      // Drain with no new product: data registers keep their last value.
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_cj    = rsp_cj_q;
  assign bus.rsp_id    = rsp_id_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_cmul_rr_arbiter.sv
// tb/tb_cmul_rr_arbiter.sv - self-checking bench for cmul_rr_arbiter
module tb_cmul_rr_arbiter;
  import cmul_pkg::*;

  localparam int N    = 4;
  localparam int W    = CMUL_W;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNTW-1:0] op_count;
  logic [N-1:0] valid = '0;
  logic rsp_ready = 1'b1;
  logic [W-1:0] ta [N];
  logic [W-1:0] taj [N];
  logic [W-1:0] tbr [N];
  logic [W-1:0] tbj [N];

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic          m_v;
  logic [W-1:0]  m_c;
  logic [W-1:0]  m_cj;
  int            m_id;
  int            m_ptr;
  logic [CNTW-1:0] m_cnt;

  int exp_seq [6];

  cmul_rr_arbiter_if #(.NREQ(N), .W(W)) bus ();

  cmul_rr_arbiter #(.NREQ(N), .W(W), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  assign bus.req_valid = valid;
  assign bus.rsp_ready = rsp_ready;
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus.req_a[i*W +: W]  = ta[i];
    assign bus.req_aj[i*W +: W] = taj[i];
    assign bus.req_b[i*W +: W]  = tbr[i];
    assign bus.req_bj[i*W +: W] = tbj[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] aj,
                        input logic [W-1:0] b, input logic [W-1:0] bj);
    ta[i] = a; taj[i] = aj; tbr[i] = b; tbj[i] = bj;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Q4.4 complex product: exact integer sum, divide toward zero, clamp.
  function automatic cplx_t cmul_model(input logic [W-1:0] a, input logic [W-1:0] aj,
                                       input logic [W-1:0] b, input logic [W-1:0] bj);
    int ar, ai, br, bi, re, im;
    cplx_t r;
    ar = $signed(a); ai = $signed(aj); br = $signed(b); bi = $signed(bj);
    re = (ar * br - ai * bi) / (1 << CMUL_FRAC);
    im = (ar * bi + ai * br) / (1 << CMUL_FRAC);
    if (re > 127) re = 127;
    if (re < -128) re = -128;
    if (im > 127) im = 127;
    if (im < -128) im = -128;
    r.re = W'(re);
    r.im = W'(im);
    return r;
  endfunction

  // Model and per-cycle compare; also enforces the requester hold rule.
  initial begin : model
    int eg;
    logic [N-1:0] er;
    cplx_t p;
    logic [N-1:0] p_valid;
    logic [N-1:0] p_ready;
    logic p_rst;
    logic [4*W-1:0] p_ops [N];
    m_v = 1'b0; m_c = '0; m_cj = '0; m_id = 0; m_ptr = N - 1; m_cnt = '0;
    p_valid = '0; p_ready = '0; p_rst = 1'b0;
    for (int i = 0; i < N; i++) p_ops[i] = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      eg = -1;
      if (rst_n && (!m_v || rsp_ready)) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (eg < 0 && valid[j]) eg = j;
        end
      end
      er = (eg >= 0) ? (N'(1) << eg) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_v));
      chk("rsp_c", 32'(bus.rsp_c), 32'(m_c));
      chk("rsp_cj", 32'(bus.rsp_cj), 32'(m_cj));
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      chk("op_count", 32'(op_count), 32'(m_cnt));
      for (int i = 0; i < N; i++) begin
        if (p_rst && rst_n && p_valid[i] && !p_ready[i]) begin
          assert (valid[i] && p_ops[i] == {ta[i], taj[i], tbr[i], tbj[i]})
            else $error("requester %0d dropped or changed an unaccepted request", i);
        end
        p_ops[i] = {ta[i], taj[i], tbr[i], tbj[i]};
      end
      p_valid = valid;
      p_ready = bus.req_ready;
      p_rst   = rst_n;
      if (!rst_n) begin
        m_v = 1'b0; m_c = '0; m_cj = '0; m_id = 0; m_ptr = N - 1; m_cnt = '0;
      end else if (eg >= 0) begin
        p = cmul_model(ta[eg], taj[eg], tbr[eg], tbj[eg]);
        m_c = p.re; m_cj = p.im; m_id = eg; m_ptr = eg; m_v = 1'b1;
        if (m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end else if (m_v && rsp_ready) begin
        m_v = 1'b0;
      end
    end
  end

  initial begin : stim
    exp_seq = '{0, 1, 2, 3, 0, 1};
    set_op(0, 8'hF0, 8'hFA, 8'h0D, 8'hF8);
    set_op(1, 8'h10, 8'h00, 8'h20, 8'h08);
    set_op(2, 8'h08, 8'h0C, 8'h09, 8'h0B);
    set_op(3, 8'h7F, 8'h80, 8'h7F, 8'h7F);
    valid = '1;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    step();

    // reset held with every requester valid
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_op_count", 32'(op_count), 32'h0);
      step();
    end

    // all valid, full throughput: strict rotation from requester 0
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("grant_order", 32'(oh2i(bus.req_ready)), 32'(exp_seq[k]));
      if (k == 1) begin
        chk("rr0_c", 32'(bus.rsp_c), 32'hF0);
        chk("rr0_cj", 32'(bus.rsp_cj), 32'h03);
        chk("rr0_count", 32'(op_count), 32'd1);
      end
      if (k == 3) begin
        chk("rr2_c", 32'(bus.rsp_c), 32'hFD);
        chk("rr2_cj", 32'(bus.rsp_cj), 32'h0C);
        chk("rr2_id", 32'(bus.rsp_id), 32'd2);
      end
      if (k == 4) begin
        chk("sat_c", 32'(bus.rsp_c), 32'h7F);
        chk("sat_cj", 32'(bus.rsp_cj), 32'hF9);
      end
      step();
    end

    // reset while a response is pending
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.req_ready), 32'h0);
    chk("midrst_pending", 32'(bus.rsp_valid), 32'h1);
    step();
    @(negedge clk);
    chk("midrst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst_count", 32'(op_count), 32'h0);
    step();

    // single request from requester 0
    rst_n = 1'b1;
    valid = 4'b0001;
    @(negedge clk);
    chk("single_grant", 32'(bus.req_ready), 32'h1);
    step();
    valid = 4'b0010;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("single_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_c", 32'(bus.rsp_c), 32'hF0);
    chk("single_cj", 32'(bus.rsp_cj), 32'h03);
    chk("single_id", 32'(bus.rsp_id), 32'h0);
    chk("single_count", 32'(op_count), 32'd1);

    // backpressure: five more stalled cycles
    for (int s = 0; s < 5; s++) begin
      step();
      @(negedge clk);
      chk("stall_ready", 32'(bus.req_ready), 32'h0);
      chk("stall_valid", 32'(bus.rsp_valid), 32'h1);
      chk("stall_c", 32'(bus.rsp_c), 32'hF0);
      chk("stall_id", 32'(bus.rsp_id), 32'h0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("resume_grant", 32'(bus.req_ready), 32'b0010);

    // sparse: ptr=1, requesters 1 and 3 valid
    step();
    valid = 4'b1010;
    @(negedge clk);
    chk("resume_c", 32'(bus.rsp_c), 32'h20);
    chk("resume_cj", 32'(bus.rsp_cj), 32'h08);
    chk("resume_id", 32'(bus.rsp_id), 32'd1);
    chk("sparse_first", 32'(bus.req_ready), 32'b1000);
    step();
    valid = 4'b0010;
    @(negedge clk);
    chk("sparse_second", 32'(bus.req_ready), 32'b0010);
    chk("sparse_id3", 32'(bus.rsp_id), 32'd3);
    step();
    valid = 4'b0000;
    @(negedge clk);
    chk("sparse_id1", 32'(bus.rsp_id), 32'd1);
    chk("sparse_noidle", 32'(bus.rsp_valid), 32'h1);

    // op_count saturation
    step();
    force dut.cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step();
    release dut.cnt_q;
    valid = 4'b0001;
    @(negedge clk);
    chk("sat_grant", 32'(bus.req_ready), 32'b0001);
    step();
    valid = 4'b0000;
    @(negedge clk);
    chk("sat_count", 32'(op_count), 32'hFFFF);
    chk("sat_id", 32'(bus.rsp_id), 32'd0);
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmul_rr_arbiter.md
Name: cmul_rr_arbiter

Overview:
Shares one combinational complex multiplier (`complex_mul`, Q4.4 signed operands) between NREQ requesters, for example butterfly units of the 32-point FFT.
- A round-robin arbiter selects one requester per cycle and feeds its operand pair to the multiplier.
- The product is registered into a single-entry response buffer with valid/ready backpressure.
- The block provides fair, single-multiplier time-multiplexing with 1-cycle latency and full throughput.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand/result width, signed Q4.4 (4 integer bits, 4 fraction bits)
CNTW, 16, width of the accepted-operation counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester grant/accept
req_a  in  NREQ*W  real part of operand A, requester i at [i*W +: W]
req_aj  in  NREQ*W  imaginary part of operand A
req_b  in  NREQ*W  real part of operand B
req_bj  in  NREQ*W  imaginary part of operand B
rsp_valid  out  1  product valid
rsp_ready  in  1  downstream accepts product
rsp_c  out  W  real part of the product
rsp_cj  out  W  imaginary part of the product
rsp_id  out  $clog2(NREQ)  index of the requester that produced the product
op_count  out  CNTW  saturating count of accepted operations

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - rsp_valid=0, rsp_c=0, rsp_cj=0, rsp_id=0, op_count=0.
  - Last-grant pointer ptr=NREQ-1, so requester 0 has first priority.
- Buffer free: free = !rsp_valid || rsp_ready. This is combinational, so a drain and a new accept can happen in the same cycle.
- Grant:
  - When free, grant the first i with req_valid[i]=1, searching in order ptr+1, ptr+2, ... wrapping modulo NREQ.
  - req_ready is one-hot on that i, and all-zero when not free or when no requester is valid.
  - req_ready depends combinationally on req_valid, rsp_valid, rsp_ready and ptr. It never depends on operand data.
- Accept (req_valid[i] && req_ready[i]):
  - Requester i's operands drive the `complex_mul` inputs.
  - At the next edge: rsp_c/rsp_cj take the multiplier outputs, rsp_id=i, rsp_valid=1, ptr=i, op_count increments.
  - op_count saturates at all-ones.
- Drain without accept (rsp_valid && rsp_ready, no grant): rsp_valid goes to 0 at the next edge; data registers hold their values.
- Stall (rsp_valid && !rsp_ready): rsp_* hold stable, all req_ready=0, ptr holds.
- Latency: 1 cycle from accept to rsp_valid. Throughput: 1 product per cycle when rsp_ready=1.
- Arithmetic: rsp_c/rsp_cj are the `complex_mul` outputs unmodified, W bits, Q4.4. The multiplier's rounding and overflow rules are inherited unchanged; the arbiter does no width conversion.
- Requester obligation: hold req_valid and operands stable until accepted. The verification bench asserts this rule.
- Fairness: any continuously valid requester is granted within NREQ grants.
- Reset mid-operation: a pending response is discarded (rsp_valid=0), ptr and op_count reinitialise, and no req_ready is asserted during the reset cycle.
- Ungated requester: a requester with req_valid=0 is skipped with no lost cycle.

Decomposition:
- Package cmul_pkg:
  - constants CMUL_W=8, CMUL_FRAC=4;
  - typedef cplx_t (re, im: signed [CMUL_W-1:0]);
  - function for the requester index width.
- Sub-module rr_pick:
  - combinational round-robin priority picker;
  - inputs: req vector, ptr, enable;
  - outputs: one-hot grant and encoded index.
- `complex_mul` is instantiated once, as is.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, op_count=0. First grant after release goes to requester 0.
2. Single request: requester 0 sends a=F0 aj=FA b=0D bj=F8 and is accepted at cycle t -> at t+1 rsp_valid=1, rsp_c=F0, rsp_cj=03, rsp_id=0, op_count=1.
3. All NREQ=4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles. Requester 2 with operands 08,0C,09,0B produces rsp_c=FD, rsp_cj=0C.
4. Backpressure: rsp_valid=1 and rsp_ready=0 for 5 cycles -> req_ready=0 and rsp_* unchanged throughout. In the cycle rsp_ready rises, a new grant occurs and the new product appears on the next cycle.
5. Sparse requests: with ptr=1, only requesters 1 and 3 are valid -> grant 3 then 1, with no idle cycle.
6. Reset mid-operation: rst_n=0 while rsp_valid=1 -> rsp_valid=0 at the next edge and the next grant goes to requester 0. Separately, preload op_count to FFFF (force) -> it stays FFFF after a further accept.
